// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_pkg
// Description : Shared opcodes, controller state encoding and widths for the
//               8-bit RISC CPU.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int OP_W    = 3;
    localparam int INSTR_W = 16;

    localparam logic [OP_W-1:0] OP_HLT  = 3'b000;
    localparam logic [OP_W-1:0] OP_SKZ  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
    localparam logic [OP_W-1:0] OP_ANDD = 3'b011;
    localparam logic [OP_W-1:0] OP_XORR = 3'b100;
    localparam logic [OP_W-1:0] OP_LDA  = 3'b101;
    localparam logic [OP_W-1:0] OP_STO  = 3'b110;
    localparam logic [OP_W-1:0] OP_JMP  = 3'b111;

    typedef enum logic [3:0] {
        S0   = 4'd0,
        S1   = 4'd1,
        S2   = 4'd2,
        S3   = 4'd3,
        S4   = 4'd4,
        S5   = 4'd5,
        S6   = 4'd6,
        S7   = 4'd7,
        HALT = 4'd8
    } state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/machine_ctl.sv
`default_nettype none
// ============================================================================
// Module      : machine_ctl
// Description : Eight-state instruction-cycle controller; decodes state,
//               opcode and zero flag into datapath strobes.
// Revision    : 1.0  initial release
// ============================================================================
module machine_ctl
    import cpu_pkg::*;
#(
    parameter int OP_W    = cpu_pkg::OP_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [INSTR_W-1:0] instr,
    input  logic               zero,
    output logic               load_ir,
    output logic               inc_pc,
    output logic               load_pc,
    output logic               rd,
    output logic               wr,
    output logic               load_acc,
    output logic               datactl_ena,
    output logic               addr_sel,
    output logic               halt
);

    state_t            r_state;
    logic [OP_W-1:0]   w_op;
    logic              w_alu_or_lda;
    logic              w_unused;

    logic w_load_ir, w_inc_pc, w_load_pc, w_rd, w_wr;
    logic w_load_acc, w_datactl_ena, w_addr_sel, w_halt;

    assign w_op         = instr[INSTR_W-1 -: OP_W];
    assign w_unused     = ^instr[INSTR_W-OP_W-1:0];
    assign w_alu_or_lda = (w_op == OP_ADD) || (w_op == OP_ANDD) ||
                          (w_op == OP_XORR) || (w_op == OP_LDA);

    // HALT is left only through rst; ena merely freezes the running cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S0;
        end else if (ena) begin
            case (r_state)
                S0:      r_state <= S1;
                S1:      r_state <= S2;
                S2:      r_state <= S3;
                S3:      r_state <= (w_op == OP_HLT) ? HALT : S4;
                S4:      r_state <= S5;
                S5:      r_state <= S6;
                S6:      r_state <= S7;
                S7:      r_state <= S0;
                HALT:    r_state <= HALT;
                default: r_state <= S0;
            endcase
        end
    end

    always_comb begin
        w_load_ir     = 1'b0;
        w_inc_pc      = 1'b0;
        w_load_pc     = 1'b0;
        w_rd          = 1'b0;
        w_wr          = 1'b0;
        w_load_acc    = 1'b0;
        w_datactl_ena = 1'b0;
        w_addr_sel    = 1'b0;
        w_halt        = 1'b0;
        if (!rst) begin
            if (r_state == HALT) begin
                w_halt = 1'b1;
            end else if (ena) begin
                case (r_state)
                    S0, S1: begin
                        w_rd      = 1'b1;
                        w_load_ir = 1'b1;
                        w_inc_pc  = 1'b1;
                    end
                    S3: w_halt = (w_op == OP_HLT);
                    S4: begin
                        if (w_alu_or_lda) begin
                            w_addr_sel = 1'b1;
                            w_rd       = 1'b1;
                        end else if (w_op == OP_STO) begin
                            w_addr_sel    = 1'b1;
                            w_datactl_ena = 1'b1;
                        end else if (w_op == OP_JMP) begin
                            w_load_pc = 1'b1;
                        end else if (w_op == OP_SKZ) begin
                            w_inc_pc = zero;
                        end
                    end
                    S5: begin
                        if (w_alu_or_lda) begin
                            w_addr_sel = 1'b1;
                            w_rd       = 1'b1;
                            w_load_acc = 1'b1;
                        end else if (w_op == OP_STO) begin
                            w_addr_sel    = 1'b1;
                            w_datactl_ena = 1'b1;
                            w_wr          = 1'b1;
                        end else if (w_op == OP_SKZ) begin
                            w_inc_pc = zero;
                        end
                    end
                    // Keep the bus driven one cycle past the write strobe
                    S6: begin
                        if (w_op == OP_STO) begin
                            w_addr_sel    = 1'b1;
                            w_datactl_ena = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign load_ir     = w_load_ir;
    assign inc_pc      = w_inc_pc;
    assign load_pc     = w_load_pc;
    assign rd          = w_rd;
    assign wr          = w_wr;
    assign load_acc    = w_load_acc;
    assign datactl_ena = w_datactl_ena;
    assign addr_sel    = w_addr_sel;
    assign halt        = w_halt;

endmodule : machine_ctl
`default_nettype wire

// File: tb/tb_machine_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_machine_ctl
// Description : Scoreboard bench for machine_ctl with hand-computed strobes.
// Revision    : 1.0  initial release
// ============================================================================
module tb_machine_ctl;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [15:0] instr;
    logic        zero;
    logic load_ir, inc_pc, load_pc, rd, wr, load_acc, datactl_ena, addr_sel, halt;

    // Vector order: load_ir inc_pc load_pc rd wr load_acc datactl_ena addr_sel halt
    localparam logic [8:0] c_NONE  = 9'b000000000;
    localparam logic [8:0] c_FETCH = 9'b110100000;
    localparam logic [8:0] c_ALU4  = 9'b000100010;
    localparam logic [8:0] c_ALU5  = 9'b000101010;
    localparam logic [8:0] c_STO4  = 9'b000000110;
    localparam logic [8:0] c_STO5  = 9'b000010110;
    localparam logic [8:0] c_INC   = 9'b010000000;
    localparam logic [8:0] c_JMP4  = 9'b001000000;
    localparam logic [8:0] c_HALT  = 9'b000000001;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];
    string      name_q[$];

    machine_ctl u_dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .instr       (instr),
        .zero        (zero),
        .load_ir     (load_ir),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .rd          (rd),
        .wr          (wr),
        .load_acc    (load_acc),
        .datactl_ena (datactl_ena),
        .addr_sel    (addr_sel),
        .halt        (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every cycle is an output cycle, sampled mid-period
    always @(negedge clk) begin
        logic [8:0] act;
        logic [8:0] exp;
        string      nm;
        act = {load_ir, inc_pc, load_pc, rd, wr, load_acc, datactl_ena, addr_sel, halt};
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", nm, act, exp);
            end
            checks++;
            if ((rd & wr) || (load_pc & inc_pc)) begin
                errors++;
                $display("FAIL %s invariant: got rd/wr/load_pc/inc_pc %b%b%b%b expected no overlap",
                         nm, rd, wr, load_pc, inc_pc);
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic [8:0] exp, input string nm);
        rst = r;
        ena = e;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // One full enabled instruction, e[i] is the expected vector in state Si
    task automatic run8(input logic [15:0] ins, input logic z, input logic [7:0][8:0] e,
                        input string nm);
        instr = ins;
        zero  = z;
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, e[i], $sformatf("%s_S%0d", nm, i));
    endtask

    initial begin
        rst   = 1'b1;
        ena   = 1'b0;
        instr = 16'h0000;
        zero  = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, c_NONE, "reset");

        run8(16'h4000, 1'b0, {c_NONE, c_NONE, c_ALU5, c_ALU4, c_NONE, c_NONE, c_FETCH, c_FETCH}, "ADD");
        run8(16'hC123, 1'b0, {c_NONE, c_STO4, c_STO5, c_STO4, c_NONE, c_NONE, c_FETCH, c_FETCH}, "STO");
        run8(16'h2000, 1'b1, {c_NONE, c_NONE, c_INC,  c_INC,  c_NONE, c_NONE, c_FETCH, c_FETCH}, "SKZ_z1");
        run8(16'h2000, 1'b0, {c_NONE, c_NONE, c_NONE, c_NONE, c_NONE, c_NONE, c_FETCH, c_FETCH}, "SKZ_z0");
        run8(16'hE0FF, 1'b0, {c_NONE, c_NONE, c_NONE, c_JMP4, c_NONE, c_NONE, c_FETCH, c_FETCH}, "JMP");
        run8(16'h6000, 1'b0, {c_NONE, c_NONE, c_ALU5, c_ALU4, c_NONE, c_NONE, c_FETCH, c_FETCH}, "ANDD");
        run8(16'h8000, 1'b0, {c_NONE, c_NONE, c_ALU5, c_ALU4, c_NONE, c_NONE, c_FETCH, c_FETCH}, "XORR");

        // LDA frozen in S4 for three cycles, then resumes at S4
        instr = 16'hA010;
        zero  = 1'b0;
        step(1'b0, 1'b1, c_FETCH, "LDA_S0");
        step(1'b0, 1'b1, c_FETCH, "LDA_S1");
        step(1'b0, 1'b1, c_NONE,  "LDA_S2");
        step(1'b0, 1'b1, c_NONE,  "LDA_S3");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, c_NONE, $sformatf("LDA_frozen%0d", i));
        step(1'b0, 1'b1, c_ALU4, "LDA_S4");
        step(1'b0, 1'b1, c_ALU5, "LDA_S5");
        step(1'b0, 1'b1, c_NONE, "LDA_S6");
        step(1'b0, 1'b1, c_NONE, "LDA_S7");

        // Reset asserted in S5 of an ADD
        instr = 16'h4000;
        step(1'b0, 1'b1, c_FETCH, "ABORT_S0");
        step(1'b0, 1'b1, c_FETCH, "ABORT_S1");
        step(1'b0, 1'b1, c_NONE,  "ABORT_S2");
        step(1'b0, 1'b1, c_NONE,  "ABORT_S3");
        step(1'b0, 1'b1, c_ALU4,  "ABORT_S4");
        step(1'b1, 1'b1, c_NONE,  "ABORT_rst");
        step(1'b0, 1'b1, c_FETCH, "ABORT_refetch");
        step(1'b0, 1'b1, c_FETCH, "ABORT_refetch_S1");
        step(1'b0, 1'b1, c_NONE,  "ABORT_S2b");
        step(1'b0, 1'b1, c_NONE,  "ABORT_S3b");
        step(1'b0, 1'b1, c_ALU4,  "ABORT_S4b");
        step(1'b0, 1'b1, c_ALU5,  "ABORT_S5b");
        step(1'b0, 1'b1, c_NONE,  "ABORT_S6b");
        step(1'b0, 1'b1, c_NONE,  "ABORT_S7b");

        // HLT: halt from S3 onward, ena toggling has no effect
        instr = 16'h0000;
        step(1'b0, 1'b1, c_FETCH, "HLT_S0");
        step(1'b0, 1'b1, c_FETCH, "HLT_S1");
        step(1'b0, 1'b1, c_NONE,  "HLT_S2");
        step(1'b0, 1'b1, c_HALT,  "HLT_S3");
        for (int i = 0; i < 20; i++)
            step(1'b0, i[0], c_HALT, $sformatf("HLT_hold%0d", i));
        step(1'b1, 1'b1, c_NONE,  "HLT_rst");
        instr = 16'h4000;
        step(1'b0, 1'b1, c_FETCH, "HLT_exit_S0");
        step(1'b0, 1'b1, c_FETCH, "HLT_exit_S1");

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_machine_ctl
`default_nettype wire
